// File: rtl/coeff_acc_pkg.sv
// Shared types and sizing helpers for the prestep coefficient accumulator.
// Included by the top level and by the lane adder.
package coeff_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    function automatic int groups(input int cges, input int lanes);
        return (cges + lanes - 1) / lanes;
    endfunction

    localparam int GROUPS_D = groups(49, 7);
    localparam int GW       = $clog2(GROUPS_D + 1);

endpackage

// File: rtl/lane_adder.sv
// Combinational signed sum of one group of LANES terms.
// Result is MAX bits wide with no extra growth.
module lane_adder
    import coeff_acc_pkg::*;
#(
    parameter int MAX   = 38,
    parameter int LANES = 7
) (
    input  logic signed [MAX-1:0] i_terms [LANES],
    output logic signed [MAX-1:0] o_sum
);

    always_comb begin
        o_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            o_sum = o_sum + i_terms[l];
        end
    end

endmodule

// File: rtl/coeff_accumulator.sv
// Sums one captured coefficient vector, LANES terms per cycle,
// and presents the signed total through a valid/ready output.
module coeff_accumulator
    import coeff_acc_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int CGES  = 49,
    parameter int MAX   = $clog2(CGES) + BITS,
    parameter int LANES = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [MAX-1:0] coeff [CGES-1:0],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [MAX-1:0] sum,
    output logic                  busy
);

    localparam int GROUPS = groups(CGES, LANES);
    localparam int GRPW_N = $clog2(GROUPS + 1);
    localparam int GRPW   = (GW > GRPW_N) ? GW : GRPW_N;
    localparam int IW     = (CGES > 1) ? $clog2(CGES) : 1;
    localparam logic [GRPW-1:0] GRP_LAST = GRPW'(GROUPS - 1);

    state_t                r_state;
    logic signed [MAX-1:0] r_cap [CGES-1:0];
    logic signed [MAX-1:0] r_acc;
    logic signed [MAX-1:0] r_sum;
    logic [GRPW-1:0]       r_grp;
    logic                  r_out_valid;

    logic signed [MAX-1:0] w_terms [LANES];
    logic signed [MAX-1:0] w_grp_sum;
    logic signed [MAX-1:0] w_next;

    // Lanes past the end of the vector in the last group read as zero.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            int idx;
            idx = int'(r_grp) * LANES + l;
            w_terms[l] = '0;
            if (idx < CGES) begin
                w_terms[l] = r_cap[IW'(idx)];
            end
        end
    end

    lane_adder #(
        .MAX   (MAX),
        .LANES (LANES)
    ) u_lane_adder (
        .i_terms (w_terms),
        .o_sum   (w_grp_sum)
    );

    assign w_next = r_acc + w_grp_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_grp       <= '0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_cap   <= coeff;
                        r_acc   <= '0;
                        r_grp   <= '0;
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    r_acc <= w_next;
                    r_grp <= r_grp + GRPW'(1);
                    if (r_grp == GRP_LAST) begin
                        r_sum       <= w_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_cap   <= coeff;
                            r_acc   <= '0;
                            r_grp   <= '0;
                            r_state <= ACC;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // DONE passes downstream readiness through so a new vector can
    // be taken on the same edge as the result handshake.
    always_comb begin
        in_ready = 1'b0;
        unique case (r_state)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_coeff_accumulator.sv
// Randomized self-checking bench for coeff_accumulator, comparing
// against a plain arithmetic sum of each submitted vector.
module tb_coeff_accumulator;

    localparam int CGES = 49;
    localparam int MAX  = 38;

    typedef logic signed [MAX-1:0] vec_t [CGES-1:0];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    vec_t coeff;

    logic                  in_ready7, out_valid7, busy7;
    logic signed [MAX-1:0] sum7;
    logic                  in_ready5, out_valid5, busy5;
    logic signed [MAX-1:0] sum5;

    bit                    tsel = 1'b0;
    logic                  m_ir, m_ov;
    logic signed [MAX-1:0] m_sum;

    int chk = 0;
    int fail = 0;

    always #5 clk = ~clk;

    coeff_accumulator #(.BITS(32), .CGES(CGES), .LANES(7)) u7 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready7),
        .coeff     (coeff),
        .out_valid (out_valid7),
        .out_ready (out_ready),
        .sum       (sum7),
        .busy      (busy7)
    );

    coeff_accumulator #(.BITS(32), .CGES(CGES), .LANES(5)) u5 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready5),
        .coeff     (coeff),
        .out_valid (out_valid5),
        .out_ready (out_ready),
        .sum       (sum5),
        .busy      (busy5)
    );

    assign m_ir  = tsel ? in_ready5 : in_ready7;
    assign m_ov  = tsel ? out_valid5 : out_valid7;
    assign m_sum = tsel ? sum5 : sum7;

    function automatic longint model_sum(input vec_t v);
        longint s = 0;
        for (int i = 0; i < CGES; i++) s += longint'(v[i]);
        return s;
    endfunction

    function automatic vec_t vec_const(input longint c);
        vec_t v;
        for (int i = 0; i < CGES; i++) v[i] = MAX'(c);
        return v;
    endfunction

    function automatic vec_t vec_rand();
        vec_t v;
        for (int i = 0; i < CGES; i++) begin
            int x;
            x = $urandom();
            v[i] = x;
        end
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Submit one vector, wait for its result, hold out_ready low for
    // `hold` cycles while watching stability, then complete the handshake.
    task automatic run_vec(input vec_t v, input int hold,
                           output logic signed [MAX-1:0] got,
                           output int lat, output bit stable);
        int n = 0;
        @(negedge clk);
        while (!m_ir && n < 60) begin
            @(negedge clk);
            n++;
        end
        coeff = v;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        coeff = vec_rand();
        lat = 0;
        while (!m_ov && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        got = m_sum;
        stable = m_ov;
        repeat (hold) begin
            @(negedge clk);
            if (!m_ov || m_sum !== got || m_ir) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        chk++;
        if (in_ready7 !== 1'b1 || out_valid7 !== 1'b0 || busy7 !== 1'b0) begin
            fail++;
            $display("FAIL reset_ctrl: ir=%b ov=%b busy=%b want 1 0 0",
                     in_ready7, out_valid7, busy7);
        end
        chk++;
        if (sum7 !== '0 || sum5 !== '0 || busy5 !== 1'b0) begin
            fail++;
            $display("FAIL reset_sum: sum7=%0d sum5=%0d busy5=%b want 0 0 0",
                     sum7, sum5, busy5);
        end
    endtask

    task automatic test_ones();
        int n = 0;
        bit ir_low = 1'b1;
        tsel = 1'b0;
        @(negedge clk);
        coeff = vec_const(1);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid7 && n < 60) begin
            if (in_ready7 !== 1'b0 || busy7 !== 1'b1) ir_low = 1'b0;
            @(negedge clk);
            n++;
        end
        chk++;
        if (n != 7 || !ir_low) begin
            fail++;
            $display("FAIL ones_latency: lat=%0d ready_low=%b want 7 1", n, ir_low);
        end
        chk++;
        if (sum7 !== MAX'(49)) begin
            fail++;
            $display("FAIL ones_sum: got %0d want 49", sum7);
        end
        @(negedge clk);
        chk++;
        if (out_valid7 !== 1'b0 || busy7 !== 1'b0 || in_ready7 !== 1'b1) begin
            fail++;
            $display("FAIL ones_idle: ov=%b busy=%b ir=%b want 0 0 1",
                     out_valid7, busy7, in_ready7);
        end
    endtask

    task automatic test_min();
        logic signed [MAX-1:0] got;
        int lat;
        bit st;
        vec_t v;
        tsel = 1'b0;
        v = vec_const(-64'sd2147483648);
        run_vec(v, 0, got, lat, st);
        chk++;
        if (longint'(got) != -64'sd105226698752 || longint'(got) != model_sum(v)) begin
            fail++;
            $display("FAIL min_sum: got %0d want %0d", got, model_sum(v));
        end
    endtask

    task automatic test_hold();
        logic signed [MAX-1:0] got;
        int lat;
        bit st;
        vec_t v;
        tsel = 1'b0;
        for (int i = 0; i < CGES; i++) v[i] = MAX'(i);
        run_vec(v, 10, got, lat, st);
        chk++;
        if (got !== MAX'(1176) || lat != 7) begin
            fail++;
            $display("FAIL hold_sum: got %0d lat %0d want 1176 7", got, lat);
        end
        chk++;
        if (!st) begin
            fail++;
            $display("FAIL hold_stable: stable=%b want 1", st);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        tsel = 1'b0;
        @(negedge clk);
        coeff = vec_const(1);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid7 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk++;
        if (sum7 !== MAX'(49) || in_ready7 !== 1'b1) begin
            fail++;
            $display("FAIL b2b_first: sum=%0d ir=%b want 49 1", sum7, in_ready7);
        end
        coeff = vec_const(2);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        coeff = vec_rand();
        chk++;
        if (out_valid7 !== 1'b0 || busy7 !== 1'b1 || in_ready7 !== 1'b0) begin
            fail++;
            $display("FAIL b2b_nobubble: ov=%b busy=%b ir=%b want 0 1 0",
                     out_valid7, busy7, in_ready7);
        end
        n = 0;
        while (!out_valid7 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk++;
        if (n != 7 || sum7 !== MAX'(98)) begin
            fail++;
            $display("FAIL b2b_second: lat=%0d sum=%0d want 7 98", n, sum7);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic signed [MAX-1:0] got;
        int lat;
        bit st;
        bit seen = 1'b0;
        tsel = 1'b0;
        @(negedge clk);
        coeff = vec_const(5);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk++;
        if (in_ready7 !== 1'b1 || busy7 !== 1'b0 || out_valid7 !== 1'b0 || sum7 !== '0) begin
            fail++;
            $display("FAIL midreset_vals: ir=%b busy=%b ov=%b sum=%0d want 1 0 0 0",
                     in_ready7, busy7, out_valid7, sum7);
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid7) seen = 1'b1;
        end
        chk++;
        if (seen) begin
            fail++;
            $display("FAIL midreset_noout: out_valid seen=%b want 0", seen);
        end
        run_vec(vec_const(3), 0, got, lat, st);
        chk++;
        if (got !== MAX'(147) || lat != 7) begin
            fail++;
            $display("FAIL midreset_next: got %0d lat %0d want 147 7", got, lat);
        end
    endtask

    task automatic test_lanes5();
        logic signed [MAX-1:0] got;
        int lat;
        bit st;
        vec_t v;
        do_reset();
        tsel = 1'b1;
        v = vec_const(0);
        v[48] = MAX'(1);
        run_vec(v, 0, got, lat, st);
        chk++;
        if (got !== MAX'(1) || lat != 10) begin
            fail++;
            $display("FAIL lanes5_tail: got %0d lat %0d want 1 10", got, lat);
        end
    endtask

    task automatic test_random();
        logic signed [MAX-1:0] got;
        int lat;
        bit st;
        vec_t v;
        for (int k = 0; k < 12; k++) begin
            int hold;
            int want_lat;
            if (k == 0) begin
                do_reset();
                tsel = 1'b0;
            end
            if (k == 8) begin
                do_reset();
                tsel = 1'b1;
            end
            want_lat = tsel ? 10 : 7;
            v = vec_rand();
            hold = $urandom_range(0, 3);
            run_vec(v, hold, got, lat, st);
            chk++;
            if (longint'(got) != model_sum(v) || lat != want_lat || !st) begin
                fail++;
                $display("FAIL random_%0d: got %0d lat %0d stable %b want %0d %0d 1",
                         k, got, lat, st, model_sum(v), want_lat);
            end
        end
    endtask

    initial begin
        coeff = vec_const(0);
        test_reset();
        test_ones();
        test_min();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_lanes5();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
        $finish;
    end

endmodule
